// File: rtl/lcb_rx_framer.sv
// lcb_rx_framer: collects one LCB response from a UART_RX byte stream into a
// BYTES-deep buffer. A packet is armed by iStart and closed by a line-idle gap.
// Short or missing responses are padded with FILL_BYTE so every completed
// packet produces exactly BYTES writes (addresses 0..BYTES-1) and one oDone.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   iStart           one-cycle arm pulse (aborts and restarts any packet)
//   iValid, iData    byte strobe and byte from UART_RX
//   oWrAdr/oWrData/oWE  registered buffer write port (1 clk latency)
//   oDone            one-cycle pulse once the buffer holds BYTES entries
//   oBusy            high whenever the framer is not idle
//   oCount           real bytes accepted this packet (saturates at BYTES)
//   oErrShort/oErrTimeout/oErrOverflow  sticky error flags, cleared by iStart
module lcb_rx_framer #(
   parameter int unsigned BYTES       = 32,
   parameter int unsigned AW          = 5,
   parameter int unsigned GAP_CYC     = 800,
   parameter int unsigned TIMEOUT_CYC = 80000,
   parameter logic [7:0]  FILL_BYTE   = 8'h00
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          iStart,
   input  logic          iValid,
   input  logic [7:0]    iData,
   output logic [AW-1:0] oWrAdr,
   output logic [7:0]    oWrData,
   output logic          oWE,
   output logic          oDone,
   output logic          oBusy,
   output logic [AW:0]   oCount,
   output logic          oErrShort,
   output logic          oErrTimeout,
   output logic          oErrOverflow
);

   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned GW = $clog2(GAP_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_FIRST,
      S_RECV,
      S_FILL,
      S_DONE
   } state_t;

   state_t        state;
   logic [TW-1:0] tcnt;   // cycles since arm, waiting for the first byte
   logic [GW-1:0] gcnt;   // idle cycles since the last byte
   logic [CW-1:0] fptr;   // next fill address; one wider so BYTES==2^AW can be reached

   // Packet FSM with registered write port and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         tcnt         <= '0;
         gcnt         <= '0;
         fptr         <= '0;
         oWrAdr       <= '0;
         oWrData      <= '0;
         oWE          <= 1'b0;
         oDone        <= 1'b0;
         oBusy        <= 1'b0;
         oCount       <= '0;
         oErrShort    <= 1'b0;
         oErrTimeout  <= 1'b0;
         oErrOverflow <= 1'b0;
      end else begin
         oWE   <= 1'b0;
         oDone <= 1'b0;
         // Arm/abort has priority over everything, including a coincident byte.
         if (iStart) begin
            state        <= S_WAIT_FIRST;
            oBusy        <= 1'b1;
            oCount       <= '0;
            tcnt         <= '0;
            gcnt         <= '0;
            fptr         <= '0;
            oErrShort    <= 1'b0;
            oErrTimeout  <= 1'b0;
            oErrOverflow <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
               end
               S_WAIT_FIRST: begin
                  if (iValid) begin
                     oWE     <= 1'b1;
                     oWrAdr  <= '0;
                     oWrData <= iData;
                     oCount  <= CW'(1);
                     state   <= S_RECV;
                  end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                     oErrTimeout <= 1'b1;
                     fptr        <= '0;
                     state       <= S_FILL;
                  end else begin
                     tcnt <= tcnt + TW'(1);
                  end
               end
               S_RECV: begin
                  if (iValid) begin
                     gcnt <= '0;
                     if (oCount < CW'(BYTES)) begin
                        oWE     <= 1'b1;
                        oWrAdr  <= AW'(oCount);
                        oWrData <= iData;
                        oCount  <= oCount + CW'(1);
                     end else begin
                        oErrOverflow <= 1'b1;
                     end
                  end else if (gcnt == GW'(GAP_CYC - 1)) begin
                     if (oCount == CW'(BYTES)) begin
                        oDone <= 1'b1;
                        state <= S_DONE;
                     end else begin
                        oErrShort <= 1'b1;
                        fptr      <= oCount;
                        state     <= S_FILL;
                     end
                  end else begin
                     gcnt <= gcnt + GW'(1);
                  end
               end
               S_FILL: begin
                  // One pad write per cycle; done follows the cycle after the last write.
                  if (fptr == CW'(BYTES)) begin
                     oDone <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     oWE     <= 1'b1;
                     oWrAdr  <= AW'(fptr);
                     oWrData <= FILL_BYTE;
                     fptr    <= fptr + CW'(1);
                  end
               end
               S_DONE: begin
                  oBusy <= 1'b0;
                  state <= S_IDLE;
               end
               default: begin
                  oBusy <= 1'b0;
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lcb_rx_framer.sv
// tb_lcb_rx_framer: directed scenarios for lcb_rx_framer (BYTES=4, AW=2,
// GAP_CYC=16, TIMEOUT_CYC=100). A timestamp-based reference model predicts
// every output each cycle; literal checks pin buffer contents and timing.
module tb_lcb_rx_framer;

   localparam int BYTES   = 4;
   localparam int GAP     = 16;
   localparam int TIMEOUT = 100;

   logic       clk = 1'b0;
   logic       rst;
   logic       iStart;
   logic       iValid;
   logic [7:0] iData;
   logic [1:0] oWrAdr;
   logic [7:0] oWrData;
   logic       oWE;
   logic       oDone;
   logic       oBusy;
   logic [2:0] oCount;
   logic       oErrShort;
   logic       oErrTimeout;
   logic       oErrOverflow;

   lcb_rx_framer #(
      .BYTES(4), .AW(2), .GAP_CYC(16), .TIMEOUT_CYC(100), .FILL_BYTE(8'h00)
   ) dut (
      .clk(clk), .rst(rst), .iStart(iStart), .iValid(iValid), .iData(iData),
      .oWrAdr(oWrAdr), .oWrData(oWrData), .oWE(oWE), .oDone(oDone),
      .oBusy(oBusy), .oCount(oCount), .oErrShort(oErrShort),
      .oErrTimeout(oErrTimeout), .oErrOverflow(oErrOverflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int edge_n = 0;
   bit run = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h edge=%0d", nm, act, exp, edge_n);
      end
   endtask

   // Reference model: expected outputs after each clock edge, from timestamps.
   bit         m_active, m_idle_next;
   int         m_t_arm, m_t_last, m_nrx, m_fill;
   logic       e_we, e_done, e_busy, e_short, e_to, e_ovf;
   logic [1:0] e_adr;
   logic [7:0] e_data;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_active = 0; m_idle_next = 0; m_nrx = 0; m_fill = -1;
         m_t_arm = 0; m_t_last = 0;
         e_we = 0; e_done = 0; e_busy = 0; e_short = 0; e_to = 0; e_ovf = 0;
         e_adr = '0; e_data = '0;
      end else begin
         edge_n++;
         e_we = 0; e_done = 0;
         if (m_idle_next) begin e_busy = 0; m_idle_next = 0; end
         if (iStart) begin
            m_active = 1; m_t_arm = edge_n; m_nrx = 0; m_fill = -1;
            e_short = 0; e_to = 0; e_ovf = 0; e_busy = 1;
         end else if (m_active) begin
            if (m_fill >= 0) begin
               if (m_fill < BYTES) begin
                  e_we = 1; e_adr = 2'(m_fill); e_data = 8'h00; m_fill++;
               end else begin
                  e_done = 1; m_active = 0; m_idle_next = 1;
               end
            end else if (iValid) begin
               m_t_last = edge_n;
               if (m_nrx < BYTES) begin
                  e_we = 1; e_adr = 2'(m_nrx); e_data = iData; m_nrx++;
               end else e_ovf = 1;
            end else if (m_nrx == 0) begin
               if (edge_n - m_t_arm == TIMEOUT) begin e_to = 1; m_fill = 0; end
            end else if (edge_n - m_t_last == GAP) begin
               if (m_nrx == BYTES) begin
                  e_done = 1; m_active = 0; m_idle_next = 1;
               end else begin
                  e_short = 1; m_fill = m_nrx;
               end
            end
         end
      end
   end

   // Compare process plus buffer image and event timestamps.
   logic [7:0] mem [4];
   int         wr_edge [4];
   int         wr_cnt = 0, done_cnt = 0, done_edge = 0, to_edge = 0;
   bit         saw77 = 0, prev_to = 0;

   initial forever begin
      @(negedge clk);
      if (oWE) begin
         mem[oWrAdr] = oWrData; wr_edge[oWrAdr] = edge_n; wr_cnt++;
         if (oWrData == 8'h77) saw77 = 1;
      end
      if (oDone) begin done_cnt++; done_edge = edge_n; end
      if (oErrTimeout && !prev_to) to_edge = edge_n;
      prev_to = oErrTimeout;
      if (run) begin
         chk("we", 32'(oWE), 32'(e_we));
         if (e_we) begin
            chk("wr_adr", 32'(oWrAdr), 32'(e_adr));
            chk("wr_data", 32'(oWrData), 32'(e_data));
         end
         chk("done", 32'(oDone), 32'(e_done));
         chk("busy", 32'(oBusy), 32'(e_busy));
         chk("count", 32'(oCount), 32'(m_nrx));
         chk("flags", 32'({oErrShort, oErrTimeout, oErrOverflow}), 32'({e_short, e_to, e_ovf}));
      end
   end

   int arm_edge, strobe_edge;

   task automatic start_pkt();
      @(negedge clk); iStart = 1; arm_edge = edge_n + 1;
      @(negedge clk); iStart = 0;
   endtask

   task automatic send(input logic [7:0] d);
      @(negedge clk); iValid = 1; iData = d; strobe_edge = edge_n + 1;
      @(negedge clk); iValid = 0;
   endtask

   task automatic idle(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic wait_done(input int budget);
      int base = done_cnt;
      n_chk++;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (done_cnt != base) return;
      end
      n_err++;
      $display("FAIL wait_done no oDone within %0d cycles", budget);
   endtask

   task automatic clear_img();
      for (int i = 0; i < 4; i++) begin mem[i] = 8'hEE; wr_edge[i] = 0; end
      wr_cnt = 0; saw77 = 0;
   endtask

   task automatic chk_mem(input string nm, input logic [31:0] exp);
      chk(nm, {mem[3], mem[2], mem[1], mem[0]}, exp);
   endtask

   int base_done, base_wr;

   initial begin
      rst = 1; iStart = 0; iValid = 0; iData = 8'h00;
      repeat (3) @(negedge clk);
      #1 run = 1;
      chk("reset_outputs", 32'({oWE, oDone, oBusy, oCount, oWrAdr, oWrData}), 32'h0);
      chk("reset_flags", 32'({oErrShort, oErrTimeout, oErrOverflow}), 32'h0);
      @(negedge clk); #2 rst = 0;

      // Full packet, bytes 10 cycles apart.
      clear_img();
      start_pkt();
      send(8'hA1); idle(9); send(8'hB2); idle(9); send(8'hC3); idle(9); send(8'hD4);
      wait_done(40);
      chk_mem("s1_mem", 32'hD4C3B2A1);
      chk("s1_done_delay", 32'(done_edge - strobe_edge), 32'd16);
      chk("s1_count", 32'(oCount), 32'd4);
      chk("s1_flags", 32'({oErrShort, oErrTimeout, oErrOverflow}), 32'h0);
      chk("s1_writes", 32'(wr_cnt), 32'd4);

      // Short packet padded with fill bytes.
      idle(3); clear_img();
      start_pkt();
      send(8'h11); idle(2); send(8'h22);
      wait_done(40);
      chk_mem("s2_mem", 32'h00002211);
      chk("s2_short", 32'(oErrShort), 32'd1);
      chk("s2_count", 32'(oCount), 32'd2);
      chk("s2_fill_consecutive", 32'(wr_edge[3] - wr_edge[2]), 32'd1);
      chk("s2_writes", 32'(wr_cnt), 32'd4);

      // No response: timeout then full fill.
      idle(3); clear_img();
      start_pkt();
      wait_done(130);
      chk("s3_timeout_edge", 32'(to_edge - arm_edge), 32'd100);
      chk_mem("s3_mem", 32'h00000000);
      chk("s3_flags", 32'({oErrShort, oErrTimeout, oErrOverflow}), 32'b010);
      chk("s3_count", 32'(oCount), 32'd0);
      chk("s3_writes", 32'(wr_cnt), 32'd4);

      // Five bytes: fifth overflows.
      idle(3); clear_img();
      start_pkt();
      for (int i = 1; i <= 5; i++) begin send(8'(i)); idle(1); end
      wait_done(40);
      chk_mem("s4_mem", 32'h04030201);
      chk("s4_flags", 32'({oErrShort, oErrTimeout, oErrOverflow}), 32'b001);
      chk("s4_count", 32'(oCount), 32'd4);
      chk("s4_writes", 32'(wr_cnt), 32'd4);

      // Restart coincident with a byte: the byte is dropped, no oDone for the first packet.
      idle(3); clear_img(); base_done = done_cnt;
      start_pkt();
      send(8'hAA); idle(2); send(8'hBB); idle(2);
      @(negedge clk); iStart = 1; iValid = 1; iData = 8'h77;
      @(negedge clk); iStart = 0; iValid = 0;
      chk("s5_no_early_done", 32'(done_cnt - base_done), 32'd0);
      send(8'h5A); idle(1); send(8'h6B); idle(1); send(8'h7C); idle(1); send(8'h8D);
      wait_done(40);
      chk_mem("s5_mem", 32'h8D7C6B5A);
      chk("s5_dropped_byte", 32'(saw77), 32'd0);
      chk("s5_done_count", 32'(done_cnt - base_done), 32'd1);
      chk("s5_flags", 32'({oErrShort, oErrTimeout, oErrOverflow}), 32'h0);
      chk("s5_writes", 32'(wr_cnt), 32'd6);

      // Asynchronous reset in the middle of a packet.
      idle(3); clear_img();
      start_pkt();
      send(8'h31); idle(1); send(8'h32); idle(2);
      chk("s6_count_before", 32'(oCount), 32'd2);
      @(negedge clk); #2 rst = 1;
      #1 chk("s6_async_zero", 32'({oWE, oDone, oBusy, oCount, oWrAdr, oWrData,
                                   oErrShort, oErrTimeout, oErrOverflow}), 32'h0);
      repeat (3) @(negedge clk); #2 rst = 0;
      base_done = done_cnt; base_wr = wr_cnt;
      idle(40);
      chk("s6_no_writes", 32'(wr_cnt - base_wr), 32'd0);
      chk("s6_no_done", 32'(done_cnt - base_done), 32'd0);
      chk("s6_idle", 32'(oBusy), 32'd0);

      // Recovery after reset.
      clear_img();
      start_pkt();
      send(8'h41); send(8'h42); send(8'h43); send(8'h44);
      wait_done(40);
      chk_mem("s7_mem", 32'h44434241);

      idle(3);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
